// File: rtl/comp_pkg.sv
// Shared types and constants for the pipelined magnitude comparator.
// Holds the slice width, the per-slice result struct and the counter ceiling helper.
package comp_pkg;

    localparam int SLICE_W = 2;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } slice_res_t;

    // All-ones value for a counter of width w, clipped to 64 bits.
    function automatic logic [63:0] cnt_max(input int w);
        if (w >= 64) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Two-bit magnitude slice: produces eq/gt/lt for one slice of the operands.
module cmp2_slice
    import comp_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    output slice_res_t         o_res
);

    assign o_res.eq = (i_a == i_b);
    assign o_res.gt = (i_a >  i_b);
    assign o_res.lt = (i_a <  i_b);

endmodule

// File: rtl/pipe_mag_comparator.sv
// Two-stage elastic magnitude comparator with a saturating equality counter.
// Define COMP_SIGNED_EN to add the signed_mode port and two's-complement compares.
module pipe_mag_comparator
    import comp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef COMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    input  logic             clear_cnt,
    output logic [CNT_W-1:0] eq_count
);

    localparam int NSL = WIDTH / SLICE_W;
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(cnt_max(CNT_W));

    if ((WIDTH % SLICE_W) != 0 || WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("pipe_mag_comparator: WIDTH must be even and within 2..64");
    end

    logic [WIDTH-1:0] w_a_adj;
    logic [WIDTH-1:0] w_b_adj;
    slice_res_t       w_slice [NSL];
    slice_res_t       r_s1_res [NSL];
    logic             r_s1_valid;
    logic             r_s2_valid;
    logic             r_s2_eq;
    logic             r_s2_gt;
    logic             r_s2_lt;
    logic             w_s1_adv;
    logic             w_s2_adv;
    logic             w_comb_eq;
    logic             w_comb_gt;
    logic             w_comb_lt;
    logic             w_out_hs;
    logic [CNT_W-1:0] r_eq_count;

`ifdef COMP_SIGNED_EN
    // Flipping both sign bits maps two's complement onto offset binary,
    // so the unsigned slices then order signed values correctly.
    assign w_a_adj = {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
    assign w_b_adj = {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
`else
    assign w_a_adj = a;
    assign w_b_adj = b;
`endif

    for (genvar i = 0; i < NSL; i++) begin : g_slice
        cmp2_slice u_slice (
            .i_a   (w_a_adj[i*SLICE_W +: SLICE_W]),
            .i_b   (w_b_adj[i*SLICE_W +: SLICE_W]),
            .o_res (w_slice[i])
        );
    end

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_adv && in_valid) begin
            for (int i = 0; i < NSL; i++) begin
                r_s1_res[i] <= w_slice[i];
            end
        end
        if (w_s2_adv && r_s1_valid) begin
            r_s2_eq <= w_comb_eq;
            r_s2_gt <= w_comb_gt;
            r_s2_lt <= w_comb_lt;
        end
    end

    // Walk upward so the most significant unequal slice has the last word.
    always_comb begin
        w_comb_eq = 1'b1;
        w_comb_gt = 1'b0;
        w_comb_lt = 1'b0;
        for (int i = 0; i < NSL; i++) begin
            if (!r_s1_res[i].eq) begin
                w_comb_eq = 1'b0;
                w_comb_gt = r_s1_res[i].gt;
                w_comb_lt = r_s1_res[i].lt;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign eq        = r_s2_valid && r_s2_eq;
    assign gt        = r_s2_valid && r_s2_gt;
    assign lt        = r_s2_valid && r_s2_lt;
    assign w_out_hs  = r_s2_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_eq_count <= '0;
        end else if (clear_cnt) begin
            r_eq_count <= '0;
        end else if (w_out_hs && r_s2_eq && (r_eq_count != C_CNT_MAX)) begin
            r_eq_count <= r_eq_count + 1'b1;
        end
    end

    assign eq_count = r_eq_count;

endmodule

// File: tb/tb_pipe_mag_comparator.sv
// Directed and random checks of pipe_mag_comparator (WIDTH=8, CNT_W=4)
// against an arithmetic scoreboard model.
module tb_pipe_mag_comparator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       sm;
    logic       out_valid;
    logic       out_ready;
    logic       eq;
    logic       gt;
    logic       lt;
    logic       clear_cnt;
    logic [3:0] eq_count;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp_cnt = 0;
    bit last_hs_in;

    always #5 clk = ~clk;

    pipe_mag_comparator #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef COMP_SIGNED_EN
        .signed_mode (sm),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .clear_cnt (clear_cnt),
        .eq_count  (eq_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // 0 = equal, 1 = a greater, 2 = a less
    function automatic int ref_cmp(input logic [7:0] x, input logic [7:0] y, input logic s);
        int xi;
        int yi;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        if (xi == yi) return 0;
        if (xi > yi)  return 1;
        return 2;
    endfunction

    function automatic logic [2:0] code_bits(input int c);
        case (c)
            0:       return 3'b100;
            1:       return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    // One clock: evaluate handshakes before the edge, update model, check after.
    task automatic step();
        bit         hs_in;
        bit         hs_out;
        bit         held;
        logic [2:0] held_res;
        int         e;
        logic       s_eff;
        #1;
`ifdef COMP_SIGNED_EN
        s_eff = sm;
`else
        s_eff = 1'b0;
`endif
        hs_in    = in_valid && in_ready && rst_n;
        hs_out   = out_valid && out_ready && rst_n;
        held     = out_valid && !out_ready && rst_n;
        held_res = {eq, gt, lt};
        if (out_valid) chk("onehot", 32'(eq) + 32'(gt) + 32'(lt), 32'd1);
        else           chk("idle_zero", 32'({eq, gt, lt}), 32'd0);
        e = -1;
        if (hs_out) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("result", 32'({eq, gt, lt}), 32'(code_bits(e)));
            end
        end
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 0;
        end else if (clear_cnt) begin
            exp_cnt = 0;
        end else if (e == 0 && exp_cnt < 15) begin
            exp_cnt++;
        end
        if (hs_in) exp_q.push_back(ref_cmp(a, b, s_eff));
        last_hs_in = hs_in;
        @(posedge clk);
        @(negedge clk);
        chk("eq_count", 32'(eq_count), 32'(exp_cnt));
        if (held) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_stable", 32'({eq, gt, lt}), 32'(held_res));
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] pa[4] = '{8'h10, 8'h30, 8'h50, 8'h07};
    logic [7:0] pb[4] = '{8'h20, 8'h30, 8'h40, 8'h08};

    initial begin
        int acc;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sm = 1'b0;
        out_ready = 1'b1; clear_cnt = 1'b0;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_eq_count", 32'(eq_count), 32'd0);

        // Latency of exactly two cycles on an equal pair
        in_valid = 1'b1; a = 8'h3C; b = 8'h3C;
        step();
        in_valid = 1'b0;
        chk("lat_not_1", 32'(out_valid), 32'd0);
        step();
        chk("lat_2_valid", 32'(out_valid), 32'd1);
        chk("lat_2_eq", 32'(eq), 32'd1);
        step();
        chk("lat_eq_count", 32'(eq_count), 32'd1);

        // Back-to-back unsigned: gt, lt, eq
        in_valid = 1'b1; a = 8'h80; b = 8'h7F; step();
        a = 8'h01; b = 8'h02; step();
        a = 8'hFF; b = 8'hFF; step();
        in_valid = 1'b0;
        chk("b2b_lt_cycle", 32'({eq, gt, lt}), 32'b001);
        step();
        chk("b2b_eq_cycle", 32'({eq, gt, lt}), 32'b100);
        step();
        chk("b2b_done", 32'(out_valid), 32'd0);

`ifdef COMP_SIGNED_EN
        in_valid = 1'b1; a = 8'h80; b = 8'h7F; sm = 1'b1; step();
        in_valid = 1'b0; step();
        chk("signed_lt", 32'(lt), 32'd1);
        step();
        in_valid = 1'b1; sm = 1'b0; step();
        in_valid = 1'b0; step();
        chk("unsigned_gt", 32'(gt), 32'd1);
        step();
`endif

        // Backpressure: four pairs offered while the consumer stalls
        out_ready = 1'b0; acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; a = pa[acc]; b = pb[acc];
            step();
            if (last_hs_in) acc++;
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            in_valid = 1'b1; a = pa[acc]; b = pb[acc];
            step();
            if (last_hs_in) acc++;
        end
        chk("bp_all_accepted", 32'(acc), 32'd4);
        drain();

        // Saturation then clear colliding with an equal handshake
        clear_cnt = 1'b1; step(); clear_cnt = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; a = 8'($urandom); b = a;
            step();
        end
        drain();
        chk("sat_15", 32'(eq_count), 32'd15);
        in_valid = 1'b1; a = 8'h05; b = 8'h05; step();
        in_valid = 1'b0; out_ready = 1'b0; step();
        chk("clr_pending_eq", 32'(eq), 32'd1);
        out_ready = 1'b1; clear_cnt = 1'b1; step(); clear_cnt = 1'b0;
        chk("clr_wins", 32'(eq_count), 32'd0);

        // Reset with two pairs in flight
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'h11; b = 8'h22; step();
        a = 8'h33; b = 8'h33; step();
        in_valid = 1'b0; rst_n = 1'b0; step();
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("rst_no_stale", 32'(out_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            clear_cnt = ($urandom_range(0, 31) == 0);
            sm        = 1'($urandom_range(0, 1));
            a         = 8'($urandom);
            b         = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            step();
        end
        clear_cnt = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
